trap_sprite: RTL

- Parametrised moving-trap sprite (apple, spike, block) for the game screen.
- Stationary until the kid enters a trigger window, then moves in a chosen direction at a chosen speed until fully off-screen.
- Generates ROM address and pixel/transparency output for the VGA mixer, plus a kid-collision flag for the death logic.
- Replaces the fixed-size, downward-only, free-running-clock trap; all timing is by tick enables on the single system clock.

---
 rtl/game_pkg.sv | 24 ++
 rtl/sprite_pixel_pipe.sv | 64 ++++++
 rtl/trap_sprite.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants, direction/state encodings and small helpers.
package game_pkg;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;
    localparam logic [11:0] TRANSPARENT = 12'hFFF;

    localparam int DIR_DOWN  = 0;
    localparam int DIR_UP    = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_GONE   = 2'd2
    } state_e;

    // Width of a frame index; at least one bit even for single-frame sprites.
    function automatic int frame_bits(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

endpackage

// File: rtl/sprite_pixel_pipe.sv
// Sprite box test, ROM address generation and the 1-cycle ROM alignment stage.
module sprite_pixel_pipe
    import game_pkg::*;
#(
    parameter int SPR_W = 22,
    parameter int SPR_H = 24,
    parameter int FRAMES = 2,
    localparam int ADDR_W = $clog2(SPR_W * SPR_H * FRAMES),
    localparam int FRAME_W = frame_bits(FRAMES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          col,
    input  logic [9:0]          row,
    input  logic signed [10:0]  pos_x,
    input  logic signed [10:0]  pos_y,
    input  logic [FRAME_W-1:0]  frame,
    input  logic                visible,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [11:0]         rom_rgb,
    output logic                is_sprite,
    output logic [11:0]         sprite_rgb
);

    localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

    // 12-bit signed offsets: scan coordinates are 0..1023, positions -1024..1023.
    logic signed [11:0] off_x;
    logic signed [11:0] off_y;
    logic               in_box;
    logic               in_box_d;

    assign off_x = $signed({2'b00, col}) - $signed({pos_x[10], pos_x});
    assign off_y = $signed({2'b00, row}) - $signed({pos_y[10], pos_y});

    // Negative offsets lie left of / above the sprite and are outside the box.
    assign in_box = !off_x[11] && (int'(off_x) < SPR_W) &&
                    !off_y[11] && (int'(off_y) < SPR_H);

    // Address of the pixel inside the current animation frame.
    always_comb begin
        rom_addr = '0;
        if (in_box) begin
            rom_addr = ADDR_W'(off_x) + ADDR_W'(off_y) * ROW_SZ + ADDR_W'(frame) * FRAME_SZ;
        end
    end

    // Delay the box flag by one cycle so it lines up with the registered ROM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_box_d <= 1'b0;
        end else begin
            in_box_d <= in_box;
        end
    end

    // Transparency key and visibility gate applied to the aligned ROM pixel.
    always_comb begin
        is_sprite  = in_box_d && (rom_rgb != TRANSPARENT) && visible;
        sprite_rgb = in_box_d ? rom_rgb : 12'h000;
    end

endmodule

// File: rtl/trap_sprite.sv
// Moving trap sprite: waits for the kid to enter a trigger window, then slides
// off-screen; drives the shared pixel pipe and a registered kid-collision flag.
module trap_sprite
    import game_pkg::*;
#(
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0,
    parameter int SPR_W     = 22,
    parameter int SPR_H     = 24,
    parameter int FRAMES    = 2,
    parameter int DIR       = 0,
    parameter int STEP      = 4,
    parameter int TRIG_AXIS = 0,
    parameter int TRIG_LO   = 0,
    parameter int TRIG_HI   = 1,
    parameter int KID_W     = 11,
    parameter int KID_H     = 21,
    localparam int ADDR_W   = $clog2(SPR_W * SPR_H * FRAMES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              toggle_tick,
    input  logic              update_tick,
    input  logic              rearm,
    input  logic [9:0]        col,
    input  logic [9:0]        row,
    input  logic [9:0]        kid_x,
    input  logic [9:0]        kid_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_rgb,
    output logic              is_sprite,
    output logic [11:0]       sprite_rgb,
    output logic              kid_hit,
    output logic [1:0]        state
);

    localparam int FRAME_W = frame_bits(FRAMES);

    localparam int DX = (DIR == DIR_RIGHT) ? STEP : (DIR == DIR_LEFT) ? -STEP : 0;
    localparam int DY = (DIR == DIR_DOWN)  ? STEP : (DIR == DIR_UP)   ? -STEP : 0;

    localparam logic signed [10:0] INIT_X_S = 11'(INIT_X);
    localparam logic signed [10:0] INIT_Y_S = 11'(INIT_Y);
    localparam logic signed [10:0] DX_S     = 11'(DX);
    localparam logic signed [10:0] DY_S     = 11'(DY);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);

    state_e                state_q, state_d;
    logic signed [10:0]    pos_x_q, pos_x_d;
    logic signed [10:0]    pos_y_q, pos_y_d;
    logic signed [10:0]    move_x, move_y;
    logic [FRAME_W-1:0]    frame_q;
    logic                  hit_q;
    logic                  triggered;
    logic                  off_screen;
    logic                  overlap;
    logic [9:0]            trig_val;

    assign move_x = pos_x_q + DX_S;
    assign move_y = pos_y_q + DY_S;

    assign off_screen = (int'(move_y) >= SCREEN_H) || (int'(move_y) + SPR_H <= 0) ||
                        (int'(move_x) >= SCREEN_W) || (int'(move_x) + SPR_W <= 0);

    assign trig_val  = (TRIG_AXIS != 0) ? kid_y : kid_x;
    assign triggered = (int'(trig_val) >= TRIG_LO) && (int'(trig_val) < TRIG_HI);

    // Strict overlap: boxes that only share an edge do not collide.
    assign overlap = (int'(kid_x) < int'(pos_x_q) + SPR_W) &&
                     (int'(kid_x) + KID_W > int'(pos_x_q)) &&
                     (int'(kid_y) < int'(pos_y_q) + SPR_H) &&
                     (int'(kid_y) + KID_H > int'(pos_y_q));

    // State and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_x_q <= INIT_X_S;
            pos_y_q <= INIT_Y_S;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    // Next state and position; rearm overrides any game-logic step.
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (rearm) begin
            state_d = ST_IDLE;
            pos_x_d = INIT_X_S;
            pos_y_d = INIT_Y_S;
        end else if (update_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (triggered) begin
                        state_d = ST_MOVING;
                    end
                end
                ST_MOVING: begin
                    pos_x_d = move_x;
                    pos_y_d = move_y;
                    if (off_screen) begin
                        state_d = ST_GONE;
                    end
                end
                ST_GONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Animation frame counter, free of the game-logic tick and of rearm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (toggle_tick) begin
            frame_q <= (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
        end
    end

    // Collision sampled once per game step against the pre-step position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
        end else if (rearm) begin
            hit_q <= 1'b0;
        end else if (update_tick) begin
            hit_q <= overlap && (state_q != ST_GONE);
        end
    end

    assign kid_hit = hit_q && (state_q != ST_GONE);
    assign state   = state_q;

    sprite_pixel_pipe #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .FRAMES (FRAMES)
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .col        (col),
        .row        (row),
        .pos_x      (pos_x_q),
        .pos_y      (pos_y_q),
        .frame      (frame_q),
        .visible    (state_q != ST_GONE),
        .rom_addr   (rom_addr),
        .rom_rgb    (rom_rgb),
        .is_sprite  (is_sprite),
        .sprite_rgb (sprite_rgb)
    );

endmodule
